// File: rtl/index_check_engine.sv
// Index-record checker: fetches one DRAM record, evaluates date/risk formulas or
// applies a signed per-channel update with saturation, then writes the record back.
`timescale 1ns/1ps
module index_check_engine #(
  parameter int unsigned N_IDX     = 4,
  parameter int unsigned IDX_W     = 12,
  parameter logic [16:0] BASE_ADDR = 17'h10000,
  parameter int unsigned TH_B      = 800,
  localparam int unsigned REC_W    = N_IDX*IDX_W+16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             act,
  input  logic [2:0]             formula,
  input  logic [1:0]             mode,
  input  logic [7:0]             today_m,
  input  logic [7:0]             today_d,
  input  logic [7:0]             data_no,
  input  logic [N_IDX*IDX_W-1:0] idx,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  output logic [16:0]            ar_addr,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [REC_W-1:0]       r_data,
  input  logic                   r_err,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [16:0]            aw_addr,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [REC_W-1:0]       w_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic                   b_err,
  output logic                   out_valid,
  output logic [1:0]             warn_msg,
  output logic                   complete,
  output logic                   bus_err
);

  localparam int unsigned LOG_N = $clog2(N_IDX);
  localparam int unsigned RES_W = IDX_W + LOG_N;
  localparam logic [IDX_W-1:0] MID = {1'b0, {(IDX_W-1){1'b1}}};

  typedef enum logic [3:0] {
    S_IDLE, S_AR, S_R, S_CHK, S_RED, S_JUDGE, S_AW, S_W, S_B, S_DONE
  } state_e;
  typedef enum logic [1:0] {W_NO, W_DATE, W_RISK, W_DATA} warn_e;
  typedef enum logic [2:0] {F_A, F_B, F_C, F_D, F_E, F_H} formula_e;

  state_e   state_q, state_d;
  warn_e    warn_q;
  formula_e fsel_q;
  logic        upd_q, cvd_q, berr_q, bgot_q, clamp_q;
  logic [1:0]  shift_q;
  logic [7:0]  tm_q, td_q, rm_q, rd_q;
  logic [16:0] addr_q;
  logic [IDX_W-1:0] in_q   [N_IDX];
  logic [IDX_W-1:0] rec_q  [N_IDX];
  logic [IDX_W-1:0] dram_q [N_IDX];
  logic [IDX_W-1:0] diff_q [N_IDX];
  logic [IDX_W-1:0] new_q  [N_IDX];
  logic [N_IDX-1:0] ge_q, mid_q;
  logic [RES_W-1:0] result_q;

  logic             date_ok;
  logic [RES_W-1:0] red_res, sum_v, dsum_v, cmid_v, cge_v;
  logic [IDX_W-1:0] dmin_v, dfmax_v, dfmin_v;
  logic [IDX_W-1:0] upd_val [N_IDX];
  logic             upd_clamp;
  logic signed [IDX_W+1:0] nsum;
  logic [31:0]      thr;
  logic [REC_W-1:0] wrec;

  assign date_ok = (tm_q > rm_q) || ((tm_q == rm_q) && (td_q >= rd_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_AR;
      S_AR:    if (ar_ready) state_d = S_R;
      S_R:     if (r_valid) state_d = r_err ? S_DONE : S_CHK;
      S_CHK:   state_d = (cvd_q || (!upd_q && !date_ok)) ? S_DONE : S_RED;
      S_RED:   state_d = S_JUDGE;
      S_JUDGE: state_d = upd_q ? S_AW : S_DONE;
      S_AW:    if (aw_ready) state_d = S_W;
      S_W:     if (w_ready) state_d = S_B;
      S_B:     if (bgot_q || b_valid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    ar_valid  = (state_q == S_AR);
    r_ready   = (state_q == S_R);
    aw_valid  = (state_q == S_AW);
    w_valid   = (state_q == S_W);
    b_ready   = (state_q == S_W) || (state_q == S_B);
    ar_addr   = ar_valid ? addr_q : '0;
    aw_addr   = aw_valid ? addr_q : '0;
    w_data    = w_valid ? wrec : '0;
    out_valid = (state_q == S_DONE);
    warn_msg  = out_valid ? warn_q : W_NO;
    bus_err   = out_valid && berr_q;
    complete  = out_valid && (warn_q == W_NO) && !berr_q;
  end

  // Datapath registers: captured per state, no reset needed.
  always_ff @(posedge clk) begin
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        upd_q   <= (act == 2'd1);
        cvd_q   <= (act == 2'd2);
        fsel_q  <= (formula > 3'd5) ? F_A : formula_e'(formula);
        shift_q <= (mode == 2'd1) ? 2'd1 : (mode == 2'd3) ? 2'd2 : 2'd0;
        tm_q    <= today_m;
        td_q    <= today_d;
        addr_q  <= BASE_ADDR + {6'b0, data_no, 3'b000};
        for (int unsigned i = 0; i < N_IDX; i++)
          in_q[i] <= idx[N_IDX*IDX_W-1-i*IDX_W -: IDX_W];
        warn_q  <= W_NO;
        berr_q  <= 1'b0;
        bgot_q  <= 1'b0;
      end
      S_R: if (r_valid) begin
        for (int unsigned i = 0; i < N_IDX; i++)
          rec_q[i] <= r_data[REC_W-1-i*IDX_W -: IDX_W];
        rm_q   <= r_data[15:8];
        rd_q   <= r_data[7:0];
        berr_q <= r_err;
      end
      S_CHK: begin
        for (int unsigned i = 0; i < N_IDX; i++) begin
          dram_q[i] <= rec_q[i];
          diff_q[i] <= (rec_q[i] >= in_q[i]) ? rec_q[i] - in_q[i] : in_q[i] - rec_q[i];
          ge_q[i]   <= (rec_q[i] >= in_q[i]);
          mid_q[i]  <= (rec_q[i] >= MID);
        end
        if (!upd_q && !date_ok) warn_q <= W_DATE;
      end
      S_RED: begin
        result_q <= red_res;
        new_q    <= upd_val;
        clamp_q  <= upd_clamp;
      end
      S_JUDGE: begin
        if (upd_q)                      warn_q <= clamp_q ? W_DATA : W_NO;
        else if (32'(result_q) >= thr)  warn_q <= W_RISK;
        else                            warn_q <= W_NO;
      end
      S_W, S_B: if (b_valid) begin
        bgot_q <= 1'b1;
        berr_q <= berr_q | b_err;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum_v   = '0;
    dsum_v  = '0;
    cmid_v  = '0;
    cge_v   = '0;
    dmin_v  = dram_q[0];
    dfmax_v = diff_q[0];
    dfmin_v = diff_q[0];
    for (int unsigned i = 0; i < N_IDX; i++) begin
      sum_v  = sum_v + RES_W'(dram_q[i]);
      dsum_v = dsum_v + RES_W'(diff_q[i]);
      cmid_v = cmid_v + RES_W'(mid_q[i]);
      cge_v  = cge_v + RES_W'(ge_q[i]);
      if (dram_q[i] < dmin_v)  dmin_v  = dram_q[i];
      if (diff_q[i] > dfmax_v) dfmax_v = diff_q[i];
      if (diff_q[i] < dfmin_v) dfmin_v = diff_q[i];
    end
    unique case (fsel_q)
      F_B:     red_res = RES_W'(dfmax_v - dfmin_v);
      F_C:     red_res = RES_W'(dmin_v);
      F_D:     red_res = cmid_v;
      F_E:     red_res = cge_v;
      F_H:     red_res = dsum_v >> LOG_N;
      default: red_res = sum_v >> LOG_N;
    endcase
  end

  // Two guard bits: the unsigned+signed sum can exceed both ends of the index range.
  always_comb begin
    upd_clamp = 1'b0;
    nsum      = '0;
    for (int unsigned i = 0; i < N_IDX; i++) begin
      nsum = $signed({2'b00, dram_q[i]}) + $signed({{2{in_q[i][IDX_W-1]}}, in_q[i]});
      if (nsum[IDX_W+1]) begin
        upd_val[i] = '0;
        upd_clamp  = 1'b1;
      end else if (nsum[IDX_W]) begin
        upd_val[i] = '1;
        upd_clamp  = 1'b1;
      end else begin
        upd_val[i] = nsum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    unique case (fsel_q)
      F_B, F_H: thr = 32'(TH_B) >> shift_q;
      F_D, F_E: thr = (32'(N_IDX) > 32'(shift_q) + 32'd1) ?
                      32'(N_IDX) - 32'd1 - 32'(shift_q) : 32'd1;
      default:  thr = 32'(MID) >> shift_q;
    endcase
  end

  always_comb begin
    wrec = '0;
    for (int unsigned i = 0; i < N_IDX; i++)
      wrec[REC_W-1-i*IDX_W -: IDX_W] = new_q[i];
    wrec[15:0] = {tm_q, td_q};
  end

endmodule

// File: tb/tb_index_check_engine.sv
// Directed vector bench for index_check_engine: table of commands with
// hand-computed outcomes, plus reset-abort and an 8-channel instance.
`timescale 1ns/1ps
module tb_index_check_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready;
  logic [1:0]  act, mode, warn_msg;
  logic [2:0]  formula;
  logic [7:0]  today_m, today_d, data_no;
  logic [47:0] idx;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_err;
  logic [16:0] ar_addr, aw_addr;
  logic [63:0] r_data, w_data;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, b_err;
  logic        out_valid, complete, bus_err;

  index_check_engine #(.N_IDX(4), .IDX_W(12), .BASE_ADDR(17'h10000), .TH_B(800)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .act(act),
    .formula(formula), .mode(mode), .today_m(today_m), .today_d(today_d),
    .data_no(data_no), .idx(idx), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_err(r_err), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .b_valid(b_valid),
    .b_ready(b_ready), .b_err(b_err), .out_valid(out_valid), .warn_msg(warn_msg),
    .complete(complete), .bus_err(bus_err));

  // 8-channel, 10-bit instance with an always-ready memory
  logic        in_valid8, in_ready8, ar_valid8, ar_ready8, r_valid8, r_ready8, r_err8;
  logic        aw_valid8, aw_ready8, w_valid8, w_ready8, b_valid8, b_ready8, b_err8;
  logic        out_valid8, complete8, bus_err8;
  logic [1:0]  warn_msg8;
  logic [16:0] ar_addr8, aw_addr8;
  logic [79:0] idx8;
  logic [95:0] r_data8, w_data8;

  assign ar_ready8 = ar_valid8;
  assign r_valid8  = r_ready8;
  assign r_err8    = 1'b0;
  assign aw_ready8 = aw_valid8;
  assign w_ready8  = w_valid8;
  assign b_valid8  = b_ready8 && !w_valid8;
  assign b_err8    = 1'b0;

  index_check_engine #(.N_IDX(8), .IDX_W(10), .BASE_ADDR(17'h10000), .TH_B(800)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .act(2'd0),
    .formula(3'd4), .mode(2'd3), .today_m(8'd6), .today_d(8'd6), .data_no(8'd2),
    .idx(idx8), .ar_valid(ar_valid8), .ar_ready(ar_ready8), .ar_addr(ar_addr8),
    .r_valid(r_valid8), .r_ready(r_ready8), .r_data(r_data8), .r_err(r_err8),
    .aw_valid(aw_valid8), .aw_ready(aw_ready8), .aw_addr(aw_addr8),
    .w_valid(w_valid8), .w_ready(w_ready8), .w_data(w_data8), .b_valid(b_valid8),
    .b_ready(b_ready8), .b_err(b_err8), .out_valid(out_valid8), .warn_msg(warn_msg8),
    .complete(complete8), .bus_err(bus_err8));

  int unsigned n_vec = 0, n_bad = 0;

  typedef struct {
    logic [1:0] act; logic [2:0] f; logic [1:0] m;
    logic [7:0] tm, td, dno; logic [47:0] ix; logic [63:0] rec;
    logic rerr; int ardly; logic berr; logic rstw;
    logic [1:0] ew; logic ec, eb; int el; logic ewr; logic [63:0] ewd; int eh;
  } vec_t;

  typedef struct {
    logic [1:0] warn; logic cmp, bus; int lat; logic wrote; logic [63:0] wd;
    int hold; logic [16:0] araddr, awaddr; int npulse; logic timeout;
    logic wv_after, irdy, reached;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [47:0] ix4(input int a, b, c, d);
    return {12'(a), 12'(b), 12'(c), 12'(d)};
  endfunction

  function automatic logic [63:0] rec4(input int a, b, c, d, mm, dd);
    return {ix4(a, b, c, d), 8'(mm), 8'(dd)};
  endfunction

  function automatic logic [79:0] ix8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4), 10'(a5), 10'(a6), 10'(a7)};
  endfunction

  function automatic vec_t v(input logic [1:0] a, input logic [2:0] f, input logic [1:0] m,
                             input logic [7:0] tm, td, dno, input logic [47:0] ix,
                             input logic [63:0] rec, input logic rerr, input int ardly,
                             input logic berr, input logic rstw, input logic [1:0] ew,
                             input logic ec, eb, input int el, input logic ewr,
                             input logic [63:0] ewd, input int eh);
    vec_t t;
    t.act = a; t.f = f; t.m = m; t.tm = tm; t.td = td; t.dno = dno; t.ix = ix;
    t.rec = rec; t.rerr = rerr; t.ardly = ardly; t.berr = berr; t.rstw = rstw;
    t.ew = ew; t.ec = ec; t.eb = eb; t.el = el; t.ewr = ewr; t.ewd = ewd; t.eh = eh;
    return t;
  endfunction

  task automatic run(input vec_t t, output res_t r);
    bit acc = 0;
    int rcyc = -1, ov = -1, rc = -1;
    r = '{warn: 2'd0, cmp: 1'b0, bus: 1'b0, lat: -1, wrote: 1'b0, wd: '0, hold: 0,
          araddr: '0, awaddr: '0, npulse: 0, timeout: 1'b0, wv_after: 1'b1,
          irdy: 1'b0, reached: 1'b0};
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_valid) begin
        r.npulse++;
        if (ov < 0) begin
          ov = c; r.warn = warn_msg; r.cmp = complete; r.bus = bus_err;
        end
      end
      if (!acc && in_ready) begin
        in_valid = 1'b1; act = t.act; formula = t.f; mode = t.m;
        today_m = t.tm; today_d = t.td; data_no = t.dno; idx = t.ix; acc = 1;
      end else begin
        in_valid = 1'b0;
      end
      ar_ready = ar_valid && (r.hold >= t.ardly);
      if (ar_valid) begin
        if (ar_ready) r.araddr = ar_addr;
        r.hold++;
      end
      r_valid = r_ready; r_data = t.rec; r_err = t.rerr;
      if (r_ready) rcyc = c;
      aw_ready = aw_valid;
      if (aw_valid) r.awaddr = aw_addr;
      w_ready = w_valid;
      if (w_valid) begin r.wrote = 1'b1; r.wd = w_data; end
      b_valid = b_ready && !w_valid; b_err = t.berr;
      if (t.rstw && w_valid && rc < 0) begin
        rst = 1'b1; w_ready = 1'b0; rc = c; r.reached = 1'b1;
      end else if (rc >= 0 && c == rc + 1) begin
        r.wv_after = w_valid; r.irdy = in_ready; rst = 1'b0;
      end
      if (t.rstw && rc >= 0 && c >= rc + 12) break;
      if (!t.rstw && ov >= 0 && c >= ov + 1) break;
    end
    r.timeout = (ov < 0);
    r.lat = ov - rcyc;
    ar_ready = 0; r_valid = 0; r_err = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
    b_err = 0; in_valid = 0; rst = 0;
  endtask

  task automatic run8(input logic [79:0] ix, input logic [95:0] rec,
                      output logic [1:0] w, output logic to);
    bit acc = 0;
    to = 1'b1; w = 2'd0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid8) begin w = warn_msg8; to = 1'b0; break; end
      if (!acc && in_ready8) begin
        in_valid8 = 1'b1; idx8 = ix; r_data8 = rec; acc = 1;
      end else begin
        in_valid8 = 1'b0;
      end
    end
    in_valid8 = 1'b0;
  endtask

  vec_t vt[$];
  res_t rs;
  logic [1:0] w8;
  logic to8;

  initial begin
    vt.push_back(v(2, 0, 0, 3, 10, 0, ix4(0,0,0,0), rec4(1,2,3,4,3,11), 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
    vt.push_back(v(2, 0, 0, 3, 11, 1, ix4(0,0,0,0), rec4(1,2,3,4,3,11), 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
    vt.push_back(v(2, 0, 0, 4, 1, 3, ix4(0,0,0,0), rec4(1,2,3,4,3,31), 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 5, 5, 5, ix4(0,0,0,0), rec4(4000,4000,4000,4000,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 5, 5, 6, ix4(0,0,0,0), rec4(1000,2000,3000,100,1,1), 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 0, 3, 5, 5, 7, ix4(0,0,0,0), rec4(1000,2000,3000,100,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 2, 28, 8, ix4(0,0,0,0), rec4(4000,4000,4000,4000,3,1), 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
    vt.push_back(v(0, 1, 0, 5, 5, 9, ix4(500,500,500,500), rec4(1000,2000,3000,100,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 1, 0, 5, 5, 10, ix4(500,500,500,500), rec4(600,700,800,900,1,1), 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 2, 1, 5, 5, 11, ix4(0,0,0,0), rec4(1100,1500,2000,1024,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 2, 0, 5, 5, 12, ix4(0,0,0,0), rec4(1100,1500,2000,1024,1,1), 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 3, 0, 5, 5, 13, ix4(0,0,0,0), rec4(2047,2046,4095,3000,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 3, 3, 5, 5, 14, ix4(0,0,0,0), rec4(0,1,2,2046,1,1), 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 4, 1, 5, 5, 15, ix4(10,25,35,40), rec4(10,20,30,40,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 5, 1, 5, 5, 16, ix4(0,1000,0,500), rec4(1000,0,500,0,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 5, 0, 5, 5, 17, ix4(0,1000,0,500), rec4(1000,0,500,0,1,1), 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 6, 0, 5, 5, 18, ix4(0,0,0,0), rec4(4000,4000,4000,4000,1,1), 0, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1));
    vt.push_back(v(0, 0, 2, 5, 5, 19, ix4(0,0,0,0), rec4(1000,2000,3000,100,1,1), 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1));
    vt.push_back(v(1, 0, 0, 2, 3, 20, ix4(-100,1,1,1), rec4(50,10,10,10,12,31), 0, 0, 0, 0, 3, 0, 0, 7, 1, rec4(0,11,11,11,2,3), 1));
    vt.push_back(v(1, 0, 0, 6, 7, 21, ix4(2047,0,0,0), rec4(4000,0,0,0,1,1), 0, 0, 0, 0, 3, 0, 0, 7, 1, rec4(4095,0,0,0,6,7), 1));
    vt.push_back(v(1, 0, 0, 8, 9, 22, ix4(5,-5,0,100), rec4(100,100,100,100,1,1), 0, 0, 0, 0, 0, 1, 0, 7, 1, rec4(105,95,100,200,8,9), 1));
    vt.push_back(v(1, 0, 0, 8, 9, 23, ix4(5,-5,0,100), rec4(100,100,100,100,1,1), 0, 0, 1, 0, 0, 0, 1, 7, 1, rec4(105,95,100,200,8,9), 1));
    vt.push_back(v(0, 0, 0, 5, 5, 24, ix4(0,0,0,0), rec4(4000,4000,4000,4000,1,1), 1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 6));
    vt.push_back(v(1, 0, 0, 8, 9, 25, ix4(5,-5,0,100), rec4(100,100,100,100,1,1), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(v(1, 0, 0, 7, 7, 255, ix4(1,2,3,-4), rec4(10,20,30,40,1,1), 0, 0, 0, 0, 0, 1, 0, 7, 1, rec4(11,22,33,36,7,7), 1));

    rst = 1; in_valid = 0; act = 0; formula = 0; mode = 0; today_m = 0; today_d = 0;
    data_no = 0; idx = '0; ar_ready = 0; r_valid = 0; r_data = '0; r_err = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_err = 0;
    in_valid8 = 0; idx8 = '0; r_data8 = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset bus valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
    chk("reset warn/complete/bus_err", 64'({warn_msg, complete, bus_err}), 64'd0);

    for (int i = 0; i < vt.size(); i++) begin
      run(vt[i], rs);
      if (vt[i].rstw) begin
        chk($sformatf("v%0d reached W", i), 64'(rs.reached), 64'd1);
        chk($sformatf("v%0d w_valid after rst", i), 64'(rs.wv_after), 64'd0);
        chk($sformatf("v%0d in_ready after rst", i), 64'(rs.irdy), 64'd1);
        chk($sformatf("v%0d out_valid on abort", i), 64'(rs.npulse), 64'd0);
      end else begin
        chk($sformatf("v%0d timeout", i), 64'(rs.timeout), 64'd0);
        chk($sformatf("v%0d warn", i), 64'(rs.warn), 64'(vt[i].ew));
        chk($sformatf("v%0d complete", i), 64'(rs.cmp), 64'(vt[i].ec));
        chk($sformatf("v%0d bus_err", i), 64'(rs.bus), 64'(vt[i].eb));
        chk($sformatf("v%0d latency", i), 64'(rs.lat), 64'(vt[i].el));
        chk($sformatf("v%0d out_valid pulses", i), 64'(rs.npulse), 64'd1);
        chk($sformatf("v%0d ar_valid cycles", i), 64'(rs.hold), 64'(vt[i].eh));
        chk($sformatf("v%0d ar_addr", i), 64'(rs.araddr), 64'(17'h10000 + 17'(vt[i].dno) * 17'd8));
        chk($sformatf("v%0d write done", i), 64'(rs.wrote), 64'(vt[i].ewr));
        chk($sformatf("v%0d w_data", i), rs.wd, vt[i].ewd);
        chk($sformatf("v%0d aw_addr", i), 64'(rs.awaddr),
            vt[i].ewr ? 64'(17'h10000 + 17'(vt[i].dno) * 17'd8) : 64'd0);
      end
    end

    // Formula E on 8 channels, sensitive mode: threshold 5
    run8(ix8(50,200,250,400,10,1,1,1), {ix8(100,200,300,400,500,0,0,0), 16'h0101}, w8, to8);
    chk("n8 five ge timeout", 64'(to8), 64'd0);
    chk("n8 five ge warn", 64'(w8), 64'd2);
    run8(ix8(50,200,250,400,600,1,1,1), {ix8(100,200,300,400,500,0,0,0), 16'h0101}, w8, to8);
    chk("n8 four ge timeout", 64'(to8), 64'd0);
    chk("n8 four ge warn", 64'(w8), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
